// File: rtl/iob_soc_sut_bringup_seq.sv
// ----------------------------------------------------------------------------
// iob_soc_sut_bringup_seq
//
// Board bring-up and reset sequencer for the SUT FPGA wrapper. Waits for a
// stable PLL lock, optionally for DDR3 init_done, then pulses the Ethernet
// PHY reset, waits for the PHY to settle and finally releases system reset.
// Losing lock anywhere past WAIT_LOCK (except FAULT) restarts the sequence.
// A software request in RUN re-runs only the PHY reset / settle phases.
//
// Optional feature (macro IOB_SOC_SUT_BRINGUP_EXTMEM_EN):
//   defined   - WAIT_INIT qualifies init_done_i with a timeout into FAULT,
//               which is left by retry_i.
//   undefined - WAIT_LOCK goes straight to PHY_RST; init_done_i, retry_i and
//               INIT_TIMEOUT_CYC are unused and fault_o is tied low.
//
// Ports:
//   clk_i         system clock
//   rst_i         synchronous active-high reset
//   pll_locked_i  PLL lock (synchronous to clk_i)
//   init_done_i   DDR3 controller init done (synchronous)
//   soft_rst_i    single-cycle PHY/system re-reset request (RUN only)
//   retry_i       single-cycle request to leave FAULT
//   sys_rst_o     system reset, active-high, low only in RUN
//   phy_resetn_o  Ethernet PHY reset, active-low
//   ready_o       high in RUN
//   fault_o       high in FAULT
//   state_o       current state encoding
// ----------------------------------------------------------------------------
module iob_soc_sut_bringup_seq #(
    parameter int unsigned LOCK_STABLE_CYC  = 16,
    parameter int unsigned PHY_RST_CYC      = 1000,
    parameter int unsigned PHY_WAIT_CYC     = 5000,
    parameter int unsigned INIT_TIMEOUT_CYC = 1048575,
    parameter int unsigned CNT_W            = 24
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_locked_i,
    input  logic       init_done_i,
    input  logic       soft_rst_i,
    input  logic       retry_i,
    output logic       sys_rst_o,
    output logic       phy_resetn_o,
    output logic       ready_o,
    output logic       fault_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        StWaitLock = 3'd0,
        StWaitInit = 3'd1,
        StPhyRst   = 3'd2,
        StPhyWait  = 3'd3,
        StRun      = 3'd4,
        StFault    = 3'd5
    } state_e;

    // Terminal counts: each state leaves on the cycle its counter hits these.
    localparam logic [CNT_W-1:0] LockLast    = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] PhyRstLast  = CNT_W'(PHY_RST_CYC - 1);
    localparam logic [CNT_W-1:0] PhyWaitLast = CNT_W'(PHY_WAIT_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef IOB_SOC_SUT_BRINGUP_EXTMEM_EN
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(INIT_TIMEOUT_CYC - 1);
    logic fault_q;
`else
    logic unused_ext;
    assign unused_ext = ^{init_done_i, retry_i, (INIT_TIMEOUT_CYC == 0)};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            StWaitLock: begin
                if (!pll_locked_i) begin
                    cnt_d = '0;
                end else if (cnt_q == LockLast) begin
`ifdef IOB_SOC_SUT_BRINGUP_EXTMEM_EN
                    state_d = StWaitInit;
`else
                    state_d = StPhyRst;
`endif
                end
            end
`ifdef IOB_SOC_SUT_BRINGUP_EXTMEM_EN
            StWaitInit: begin
                // Lock loss beats init_done, which beats the timeout.
                if (!pll_locked_i) begin
                    state_d = StWaitLock;
                end else if (init_done_i) begin
                    state_d = StPhyRst;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StFault;
                end
            end
`endif
            StPhyRst: begin
                if (!pll_locked_i) begin
                    state_d = StWaitLock;
                end else if (cnt_q == PhyRstLast) begin
                    state_d = StPhyWait;
                end
            end
            StPhyWait: begin
                if (!pll_locked_i) begin
                    state_d = StWaitLock;
                end else if (cnt_q == PhyWaitLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // No timed exit, so the counter is parked to avoid wrapping.
                cnt_d = '0;
                if (!pll_locked_i) begin
                    state_d = StWaitLock;
                end else if (soft_rst_i) begin
                    state_d = StPhyRst;
                end
            end
`ifdef IOB_SOC_SUT_BRINGUP_EXTMEM_EN
            StFault: begin
                cnt_d = '0;
                if (retry_i) begin
                    state_d = StWaitLock;
                end
            end
`endif
            default: begin
                // Illegal codes (and disabled states) recover to WAIT_LOCK.
                state_d = StWaitLock;
                cnt_d   = '0;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Outputs are registered from the next state so they line up exactly with
    // state_q and never glitch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StWaitLock;
            cnt_q        <= '0;
            sys_rst_o    <= 1'b1;
            phy_resetn_o <= 1'b0;
            ready_o      <= 1'b0;
`ifdef IOB_SOC_SUT_BRINGUP_EXTMEM_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sys_rst_o    <= (state_d != StRun);
            phy_resetn_o <= (state_d == StPhyWait) || (state_d == StRun);
            ready_o      <= (state_d == StRun);
`ifdef IOB_SOC_SUT_BRINGUP_EXTMEM_EN
            fault_q      <= (state_d == StFault);
`endif
        end
    end

`ifdef IOB_SOC_SUT_BRINGUP_EXTMEM_EN
    assign fault_o = fault_q;
`else
    assign fault_o = 1'b0;
`endif

    assign state_o = state_q;

endmodule

// File: tb/tb_iob_soc_sut_bringup_seq.sv
// ----------------------------------------------------------------------------
// tb_iob_soc_sut_bringup_seq
//
// Directed bench for iob_soc_sut_bringup_seq with LOCK_STABLE_CYC=3,
// PHY_RST_CYC=4, PHY_WAIT_CYC=6, INIT_TIMEOUT_CYC=20. Expected state traces
// are written out per cycle; the output decode is derived from the state.
// Follows IOB_SOC_SUT_BRINGUP_EXTMEM_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_iob_soc_sut_bringup_seq;

`ifdef IOB_SOC_SUT_BRINGUP_EXTMEM_EN
    localparam int EXT = 1;
`else
    localparam int EXT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       pll_locked_i = 1'b0;
    logic       init_done_i = 1'b0;
    logic       soft_rst_i = 1'b0;
    logic       retry_i = 1'b0;
    logic       sys_rst_o;
    logic       phy_resetn_o;
    logic       ready_o;
    logic       fault_o;
    logic [2:0] state_o;

    int cmp = 0;
    int bad = 0;

    iob_soc_sut_bringup_seq #(
        .LOCK_STABLE_CYC (3),
        .PHY_RST_CYC     (4),
        .PHY_WAIT_CYC    (6),
        .INIT_TIMEOUT_CYC(20),
        .CNT_W           (24)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .pll_locked_i(pll_locked_i),
        .init_done_i (init_done_i),
        .soft_rst_i  (soft_rst_i),
        .retry_i     (retry_i),
        .sys_rst_o   (sys_rst_o),
        .phy_resetn_o(phy_resetn_o),
        .ready_o     (ready_o),
        .fault_o     (fault_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // {state, sys_rst, phy_resetn, ready, fault}
    function automatic logic [6:0] obs();
        return {state_o, sys_rst_o, phy_resetn_o, ready_o, fault_o};
    endfunction

    function automatic logic [6:0] exp_out(input int st);
        logic [2:0] s;
        s = 3'(st);
        return {s, (st != 4), (st == 3 || st == 4), (st == 4), (st == 5)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in the first cycle of WAIT_LOCK with rst_i released.
    task automatic apply_reset();
        rst_i = 1'b1;
        pll_locked_i = 1'b1;
        init_done_i = 1'b0;
        soft_rst_i = 1'b0;
        retry_i = 1'b0;
        step();
        rst_i = 1'b0;
    endtask

    task automatic bring_up(input int target);
        apply_reset();
        init_done_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (int'(state_o) == target) break;
            step();
        end
        if (int'(state_o) !== target) begin
            bad++;
            $display("FAIL bring_up: state=%0d want=%0d", state_o, target);
        end
        cmp++;
    endtask

    task automatic test_reset();
        bring_up(4);
        // Reset must win over every other input, including from RUN.
        rst_i = 1'b1;
        soft_rst_i = 1'b1;
        retry_i = 1'b1;
        init_done_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (obs() !== exp_out(0)) begin
                bad++;
                $display("FAIL reset c=%0d got=%b want=%b", c, obs(), exp_out(0));
            end
            cmp++;
        end
        rst_i = 1'b0;
        soft_rst_i = 1'b0;
        retry_i = 1'b0;
    endtask

    task automatic test_nominal();
        int e;
        apply_reset();
        for (int c = 0; c < 22; c++) begin
            if (EXT != 0) e = (c < 3) ? 0 : (c < 9) ? 1 : (c < 13) ? 2 : (c < 19) ? 3 : 4;
            else          e = (c < 3) ? 0 : (c < 7) ? 2 : (c < 13) ? 3 : 4;
            if (obs() !== exp_out(e)) begin
                bad++;
                $display("FAIL nominal c=%0d got=%b want=%b", c, obs(), exp_out(e));
            end
            cmp++;
            init_done_i = (EXT != 0) && (c >= 8);
            step();
        end
        init_done_i = 1'b0;
    endtask

    task automatic test_lock_glitch();
        int e;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            e = (c < 6) ? 0 : (EXT != 0) ? 1 : 2;
            if (obs() !== exp_out(e)) begin
                bad++;
                $display("FAIL lock_glitch c=%0d got=%b want=%b", c, obs(), exp_out(e));
            end
            cmp++;
            pll_locked_i = (c != 2);
            step();
        end
    endtask

    task automatic test_timeout();
        int e;
        apply_reset();
        for (int c = 0; c < 29; c++) begin
            e = (c < 3) ? 0 : (c < 23) ? 1 : (c < 28) ? 5 : 0;
            if (obs() !== exp_out(e)) begin
                bad++;
                $display("FAIL timeout c=%0d got=%b want=%b", c, obs(), exp_out(e));
            end
            cmp++;
            // In FAULT: init_done and a lock drop are both ignored.
            init_done_i = (c >= 23) && (c <= 26);
            pll_locked_i = (c != 24);
            retry_i = (c == 27);
            step();
        end
        retry_i = 1'b0;
        pll_locked_i = 1'b1;
        init_done_i = 1'b0;

        // init_done on the final allowed cycle beats the timeout.
        apply_reset();
        for (int c = 0; c < 25; c++) begin
            e = (c < 3) ? 0 : (c < 23) ? 1 : 2;
            if (obs() !== exp_out(e)) begin
                bad++;
                $display("FAIL timeout_race c=%0d got=%b want=%b", c, obs(), exp_out(e));
            end
            cmp++;
            init_done_i = (c == 22);
            step();
        end
        init_done_i = 1'b0;
    endtask

    task automatic test_lock_loss();
        int e;
        int k;
        bring_up(4);
        for (int c = 0; c < 17; c++) begin
            if (c == 0) e = 4;
            else if (c < 4) e = 0;
            else if (EXT != 0 && c == 4) e = 1;
            else begin
                k = c - 4 - EXT;
                e = (k < 4) ? 2 : (k < 10) ? 3 : 4;
            end
            if (obs() !== exp_out(e)) begin
                bad++;
                $display("FAIL lock_loss_run c=%0d got=%b want=%b", c, obs(), exp_out(e));
            end
            cmp++;
            pll_locked_i = (c != 0);
            step();
        end

        bring_up(3);
        step();
        pll_locked_i = 1'b0;
        if (obs() !== exp_out(3)) begin
            bad++;
            $display("FAIL lock_loss_wait_pre got=%b want=%b", obs(), exp_out(3));
        end
        cmp++;
        step();
        pll_locked_i = 1'b1;
        if (obs() !== exp_out(0)) begin
            bad++;
            $display("FAIL lock_loss_wait got=%b want=%b", obs(), exp_out(0));
        end
        cmp++;
    endtask

    task automatic test_soft_reset();
        int e;
        bring_up(4);
        for (int c = 0; c < 20; c++) begin
            e = (c == 0) ? 4 : (c < 5) ? 2 : (c < 11) ? 3 : (c < 13) ? 4 :
                (c < 17) ? 2 : (c < 19) ? 3 : 0;
            if (obs() !== exp_out(e)) begin
                bad++;
                $display("FAIL soft_reset c=%0d got=%b want=%b", c, obs(), exp_out(e));
            end
            cmp++;
            // c6: soft in PHY_WAIT ignored; c11: retry in RUN ignored;
            // c18: rst_i mid-PHY_WAIT.
            soft_rst_i = (c == 0) || (c == 6) || (c == 12);
            retry_i = (c == 11);
            rst_i = (c == 18);
            step();
        end
        soft_rst_i = 1'b0;
        retry_i = 1'b0;
        rst_i = 1'b0;
    endtask

    initial begin
        step();
        test_reset();
        test_nominal();
        test_lock_glitch();
`ifdef IOB_SOC_SUT_BRINGUP_EXTMEM_EN
        test_timeout();
`endif
        test_lock_loss();
        test_soft_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
